satalnk_rxprim: RTL and testbench
=================================

// Module: satalnk_rxprim
// PURPOSE
//  Single-clock RX primitive processor for the SATA link layer: a parametrised successor to the
//  continue/align remover. It sits after the RX clock-domain crossing and feeds the link FSM and
//  RX packet framer. It drops ALIGN, tracks the CONT hold state and discards scrambled junk
//  during a hold. Optionally it re-expands the held primitive, and it keeps saturating
//  link-statistics counters.
// PARAMETERS
//  P_ALIGN          32'hBC4A4A7B  ALIGN primitive value (matches sata_primitives.vh)
//  P_CONT           32'h7CAA9999  CONT primitive value (matches sata_primitives.vh)
//  OPT_EXPAND       1'b0          1: emit held primitive for every junk word while in HOLD; 0: emit nothing
//  LGCOUNT          16            width of each statistics counter
// PORTS
//  i_clk            in   1        clock
//  i_reset_n        in   1        synchronous, active-low reset
//  i_cfg_en         in   1        1: CONT processing on; 0: CONT passed through, state forced IDLE
//  i_clear_counts   in   1        synchronous clear of all statistics counters
//  i_valid          in   1        input word valid (no backpressure; sink always ready)
//  i_primitive      in   1        input word is a primitive (K-char in byte 0)
//  i_data           in   32       input word
//  o_valid          out  1        output word valid
//  o_primitive      out  1        output word is a primitive
//  o_data           out  32       output word
//  o_hold           out  1        block is in HOLD (CONT active)
//  o_align_count    out  LGCOUNT  ALIGN primitives dropped
//  o_cont_count     out  LGCOUNT  CONT primitives received
//  o_err_count      out  LGCOUNT  protocol errors (CONT with no preceding primitive)
// BEHAVIOUR
//  - Reset (i_reset_n==0 at posedge): o_valid=0, o_primitive=0, o_data=0, o_hold=0, held=0,
//    all counters=0, state=IDLE. Reset mid-HOLD returns to IDLE; the next data word passes.
//  - Latency: one register stage. An input accepted at edge N appears on the outputs after edge N.
//    When i_valid=0, o_valid=0 on the next cycle and state, held and counters are unchanged.
//  - States: IDLE (no repeatable primitive), PRIM (held = last primitive), HOLD (CONT after PRIM).
//  - Per valid input (i_cfg_en=1), in priority order:
//    * primitive==P_ALIGN: dropped (o_valid=0), state unchanged, align_count+1.
//    * primitive==P_CONT: never output, cont_count+1. PRIM->HOLD; HOLD->HOLD (redundant CONT);
//      IDLE->IDLE with err_count+1.
//    * other primitive: output as-is, held<=i_data, state->PRIM (this exits HOLD).
//    * data word in HOLD: junk. OPT_EXPAND=0: o_valid=0. OPT_EXPAND=1: o_valid=1, o_primitive=1,
//      o_data=held. State stays HOLD.
//    * data word in PRIM or IDLE: passed through, state->IDLE.
//  - i_cfg_en=0: ALIGN is still dropped and counted; CONT is output as an ordinary primitive and
//    counted; state=IDLE, o_hold=0. Deasserting i_cfg_en during HOLD leaves HOLD on the next edge.
//  - o_hold is registered: o_hold=1 exactly when state==HOLD.
//  - Counters saturate at {LGCOUNT{1'b1}} and never wrap. i_clear_counts zeroes all three;
//    a clear coincident with an increment wins (result 0).
//  - i_primitive=0 with i_data equal to P_ALIGN or P_CONT is a data word, not a primitive.
// TESTING
//  - Reset then ALIGN,X_RDY(32'h7CB55757),X_RDY,CONT,junk x4,SOF -> out X_RDY,X_RDY,SOF;
//    o_hold=1 only during the junk words; align_count=1, cont_count=1.
//  - OPT_EXPAND=1, same stimulus -> out X_RDY x2, X_RDY x4 (primitive=1), SOF.
//  - CONT directly after a data word, then 3 data words -> err_count=1, CONT dropped,
//    3 data words passed.
//  - Preload align_count to all-ones-1, send 3 ALIGNs -> count=all-ones, no wrap.
//    Assert clear together with an ALIGN -> count=0.
//  - i_cfg_en=0: X_RDY,CONT,data -> all three output unchanged (except ALIGN dropped), o_hold=0.
//  - i_reset_n=0 for 1 cycle during HOLD, then data 32'h12345678 -> passes, o_hold=0.

Source files
------------

// File: rtl/satalnk_rxprim.sv
// SATA link-layer RX primitive processor: drops ALIGN, tracks CONT hold state,
// discards (or re-expands) scrambled junk during a hold, and keeps saturating statistics.
module satalnk_rxprim #(
  parameter logic [31:0] P_ALIGN    = 32'hBC4A4A7B,
  parameter logic [31:0] P_CONT     = 32'h7CAA9999,
  parameter bit          OPT_EXPAND = 1'b0,
  parameter int unsigned LGCOUNT    = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cfg_en,
  input  logic               i_clear_counts,
  input  logic               i_valid,
  input  logic               i_primitive,
  input  logic [31:0]        i_data,
  output logic               o_valid,
  output logic               o_primitive,
  output logic [31:0]        o_data,
  output logic               o_hold,
  output logic [LGCOUNT-1:0] o_align_count,
  output logic [LGCOUNT-1:0] o_cont_count,
  output logic [LGCOUNT-1:0] o_err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRIM = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_held;
  logic [31:0] w_held_nxt;

  logic        w_is_align;
  logic        w_is_cont;
  logic        w_is_oprim;
  logic        w_is_word;

  logic        w_valid_nxt;
  logic        w_prim_nxt;
  logic [31:0] w_data_nxt;

  logic        w_inc_align;
  logic        w_inc_cont;
  logic        w_inc_err;

  logic               r_valid;
  logic               r_prim;
  logic [31:0]        r_data;
  logic [LGCOUNT-1:0] r_align_count;
  logic [LGCOUNT-1:0] r_cont_count;
  logic [LGCOUNT-1:0] r_err_count;

  // Input classification; a data word carrying a primitive's value is still data.
  always_comb begin
    w_is_align = i_valid && i_primitive && (i_data == P_ALIGN);
    w_is_cont  = i_valid && i_primitive && (i_data == P_CONT);
    w_is_oprim = i_valid && i_primitive && !w_is_align && !w_is_cont;
    w_is_word  = i_valid && !i_primitive;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    if (!i_cfg_en) begin
      w_state_nxt = ST_IDLE;
    end else if (w_is_cont) begin
      if (r_state == ST_PRIM) begin
        w_state_nxt = ST_HOLD;
      end
    end else if (w_is_oprim) begin
      w_state_nxt = ST_PRIM;
      w_held_nxt  = i_data;
    end else if (w_is_word) begin
      if (r_state != ST_HOLD) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // Output logic (registered below to give exactly one stage of latency)
  always_comb begin
    w_valid_nxt = 1'b0;
    w_prim_nxt  = 1'b0;
    w_data_nxt  = '0;
    if (i_valid && !w_is_align) begin
      if (i_cfg_en && w_is_cont) begin
        w_valid_nxt = 1'b0;
      end else if (i_cfg_en && w_is_word && (r_state == ST_HOLD)) begin
        if (OPT_EXPAND) begin
          w_valid_nxt = 1'b1;
          w_prim_nxt  = 1'b1;
          w_data_nxt  = r_held;
        end
      end else begin
        w_valid_nxt = 1'b1;
        w_prim_nxt  = i_primitive;
        w_data_nxt  = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_prim  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_prim  <= w_prim_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_inc_align = w_is_align;
    w_inc_cont  = w_is_cont;
    w_inc_err   = w_is_cont && i_cfg_en && (r_state == ST_IDLE);
  end

  // Saturating statistics; a clear overrides a coincident increment.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear_counts) begin
      r_align_count <= '0;
      r_cont_count  <= '0;
      r_err_count   <= '0;
    end else begin
      if (w_inc_align && (r_align_count != '1)) begin
        r_align_count <= r_align_count + LGCOUNT'(1);
      end
      if (w_inc_cont && (r_cont_count != '1)) begin
        r_cont_count <= r_cont_count + LGCOUNT'(1);
      end
      if (w_inc_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + LGCOUNT'(1);
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_primitive   = r_prim;
  assign o_data        = r_data;
  assign o_hold        = (r_state == ST_HOLD);
  assign o_align_count = r_align_count;
  assign o_cont_count  = r_cont_count;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_satalnk_rxprim.sv
// Directed self-checking bench: two instances (plain, and expanding with 3-bit counters).
module tb_satalnk_rxprim;

  localparam logic [31:0] ALIGN = 32'hBC4A4A7B;
  localparam logic [31:0] CONT  = 32'h7CAA9999;
  localparam logic [31:0] XRDY  = 32'h7CB55757;
  localparam logic [31:0] SOF   = 32'h7CB53737;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b1;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic        prm = 1'b0;
  logic [31:0] dat = '0;

  logic        d_valid, d_prim, d_hold;
  logic [31:0] d_data;
  logic [15:0] d_align, d_cont, d_err;
  logic        e_valid, e_prim, e_hold;
  logic [31:0] e_data;
  logic [2:0]  e_align, e_cont, e_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  satalnk_rxprim #(.OPT_EXPAND(1'b0), .LGCOUNT(16)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cfg_en(cfg_en), .i_clear_counts(clr),
    .i_valid(vld), .i_primitive(prm), .i_data(dat),
    .o_valid(d_valid), .o_primitive(d_prim), .o_data(d_data), .o_hold(d_hold),
    .o_align_count(d_align), .o_cont_count(d_cont), .o_err_count(d_err)
  );

  satalnk_rxprim #(.OPT_EXPAND(1'b1), .LGCOUNT(3)) u_exp (
    .i_clk(clk), .i_reset_n(rst_n), .i_cfg_en(cfg_en), .i_clear_counts(clr),
    .i_valid(vld), .i_primitive(prm), .i_data(dat),
    .o_valid(e_valid), .o_primitive(e_prim), .o_data(e_data), .o_hold(e_hold),
    .o_align_count(e_align), .o_cont_count(e_cont), .o_err_count(e_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one input word, clock it in, sample #1 after the edge.
  task automatic step(input logic v, input logic p, input logic [31:0] d);
    vld = v; prm = p; dat = d;
    @(posedge clk);
    #1;
    vld = 1'b0; prm = 1'b0; dat = '0;
  endtask

  task automatic chk_d(input string tag, input logic v, input logic p, input logic [31:0] d,
                       input logic h);
    chk({tag, ".d.valid"}, 32'(d_valid), 32'(v));
    if (v) begin
      chk({tag, ".d.prim"}, 32'(d_prim), 32'(p));
      chk({tag, ".d.data"}, d_data, d);
    end
    chk({tag, ".d.hold"}, 32'(d_hold), 32'(h));
  endtask

  task automatic chk_e(input string tag, input logic v, input logic p, input logic [31:0] d,
                       input logic h);
    chk({tag, ".e.valid"}, 32'(e_valid), 32'(v));
    if (v) begin
      chk({tag, ".e.prim"}, 32'(e_prim), 32'(p));
      chk({tag, ".e.data"}, e_data, d);
    end
    chk({tag, ".e.hold"}, 32'(e_hold), 32'(h));
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(d_valid), 32'd0);
    chk("rst.data", d_data, 32'd0);
    chk("rst.hold", 32'(d_hold), 32'd0);
    chk("rst.align", 32'(d_align), 32'd0);
    chk("rst.e_err", 32'(e_err), 32'd0);
    rst_n = 1'b1;

    // ALIGN, X_RDY, X_RDY, CONT, junk x4, SOF
    step(1, 1, ALIGN);  chk_d("s1.align", 0, 0, 0, 0);    chk_e("s1.align", 0, 0, 0, 0);
    step(1, 1, XRDY);   chk_d("s1.x0", 1, 1, XRDY, 0);    chk_e("s1.x0", 1, 1, XRDY, 0);
    step(1, 1, XRDY);   chk_d("s1.x1", 1, 1, XRDY, 0);    chk_e("s1.x1", 1, 1, XRDY, 0);
    step(1, 1, CONT);   chk_d("s1.cont", 0, 0, 0, 1);     chk_e("s1.cont", 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'hDEAD0000 + 32'(i));
      chk_d("s1.junk", 0, 0, 0, 1);
      chk_e("s1.junk", 1, 1, XRDY, 1);
    end
    step(1, 1, SOF);    chk_d("s1.sof", 1, 1, SOF, 0);    chk_e("s1.sof", 1, 1, SOF, 0);
    step(0, 0, 0);      chk_d("s1.idle", 0, 0, 0, 0);
    chk("s1.align_cnt", 32'(d_align), 32'd1);
    chk("s1.cont_cnt", 32'(d_cont), 32'd1);
    chk("s1.err_cnt", 32'(d_err), 32'd0);

    // Data word, CONT with no preceding primitive, 3 data words
    step(1, 0, 32'hA5A50001); chk_d("s3.d0", 1, 0, 32'hA5A50001, 0);
    step(1, 1, CONT);         chk_d("s3.cont", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0000BEE0 + 32'(i));
      chk_d("s3.data", 1, 0, 32'h0000BEE0 + 32'(i), 0);
      chk_e("s3.data", 1, 0, 32'h0000BEE0 + 32'(i), 0);
    end
    chk("s3.err_cnt", 32'(d_err), 32'd1);
    chk("s3.cont_cnt", 32'(d_cont), 32'd2);

    // Primitive-valued data words are data
    step(1, 0, ALIGN); chk_d("s3.dalign", 1, 0, ALIGN, 0);
    step(1, 0, CONT);  chk_d("s3.dcont", 1, 0, CONT, 0);
    chk("s3.align_nochg", 32'(d_align), 32'd1);

    // Saturation on the 3-bit instance: clear, 6 ALIGNs (all-ones-1), then 3 more
    clr = 1'b1; step(0, 0, 0); clr = 1'b0;
    chk("s4.clr", 32'(e_align), 32'd0);
    chk("s4.clr_cont", 32'(e_cont), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 1, ALIGN);
    chk("s4.pre", 32'(e_align), 32'd6);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, ALIGN);
      chk("s4.sat", 32'(e_align), 32'd7);
    end
    chk("s4.d_align", 32'(d_align), 32'd9);
    clr = 1'b1; step(1, 1, ALIGN); clr = 1'b0;
    chk("s4.clr_win_e", 32'(e_align), 32'd0);
    chk("s4.clr_win_d", 32'(d_align), 32'd0);
    chk("s4.clr_err", 32'(d_err), 32'd0);

    // CONT processing disabled
    cfg_en = 1'b0;
    step(1, 1, XRDY);         chk_d("s5.x", 1, 1, XRDY, 0);
    step(1, 1, ALIGN);        chk_d("s5.align", 0, 0, 0, 0);
    step(1, 1, CONT);         chk_d("s5.cont", 1, 1, CONT, 0);
    step(1, 0, 32'h55AA55AA); chk_d("s5.data", 1, 0, 32'h55AA55AA, 0);
    chk_e("s5.data", 1, 0, 32'h55AA55AA, 0);
    chk("s5.cont_cnt", 32'(d_cont), 32'd1);
    chk("s5.align_cnt", 32'(d_align), 32'd1);
    chk("s5.err_cnt", 32'(d_err), 32'd0);

    // Disable during HOLD leaves HOLD
    cfg_en = 1'b1;
    step(1, 1, XRDY); step(1, 1, CONT);
    chk_d("s5b.hold", 0, 0, 0, 1);
    cfg_en = 1'b0;
    step(0, 0, 0);    chk_d("s5b.off", 0, 0, 0, 0);
    cfg_en = 1'b1;
    step(1, 0, 32'h0F0F0F0F); chk_d("s5b.pass", 1, 0, 32'h0F0F0F0F, 0);

    // Reset during HOLD
    step(1, 1, XRDY); step(1, 1, CONT);
    step(1, 0, 32'hCAFE0001); chk_d("s6.junk", 0, 0, 0, 1);
    rst_n = 1'b0; step(0, 0, 0); rst_n = 1'b1;
    chk_d("s6.rst", 0, 0, 0, 0);
    chk("s6.rst_data", d_data, 32'd0);
    chk("s6.rst_cont", 32'(d_cont), 32'd0);
    step(1, 0, 32'h12345678); chk_d("s6.pass", 1, 0, 32'h12345678, 0);
    chk_e("s6.pass", 1, 0, 32'h12345678, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
